// File: rtl/load_store_unit.sv
// Memory-access stage: runs one valid/ready data-memory transaction at a time, aligns and extends
// load data, stalls upstream while busy. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] ALU_OUT_IN,
  input  logic [2:0]  DATA_CACHE_LOAD_IN,
  input  logic [1:0]  DATA_CACHE_STORE_IN,
  input  logic [31:0] DATA_CACHE_STORE_DATA_IN,
  input  logic        WRITE_BACK_MUX_SELECT_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  output logic        STALL_OUT,
  output logic        MEM_REQ_VALID,
  input  logic        MEM_REQ_READY,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_RESP_VALID,
  input  logic [31:0] MEM_RDATA,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] WB_DATA_OUT,
  output logic        RD_WRITE_ENABLE_OUT,
  output logic        BUS_ERROR_OUT,
  output logic        MISALIGN_OUT
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        rdWe_q, rdWe_d;
  logic        wbSel_q, wbSel_d;
  logic [2:0]  loadOp_q, loadOp_d;
  logic        isLoad_q, isLoad_d;
  logic [31:0] addr_q, addr_d;
  logic        memWe_q, memWe_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [3:0]  memStrb_q, memStrb_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [31:0] result_q, result_d;
  logic        busErr_q, busErr_d;
  logic [4:0]  wbRd_q, wbRd_d;
  logic [31:0] wbData_q, wbData_d;
  logic        wbWe_q, wbWe_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic        isLoadIn;
  logic        isMemOpIn;
  logic        trapIn;
  logic [3:0]  strbIn;
  logic [31:0] wdataIn;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData;

  // Decode the op waiting at the input: load codes win over store codes.
  always_comb begin
    isLoadIn  = (DATA_CACHE_LOAD_IN >= 3'd1) && (DATA_CACHE_LOAD_IN <= 3'd5);
    isMemOpIn = isLoadIn || (DATA_CACHE_STORE_IN != 2'b00);
    strbIn    = 4'b0000;
    wdataIn   = 32'h0;
    if (!isLoadIn) begin
      case (DATA_CACHE_STORE_IN)
        2'b01: begin
          strbIn  = 4'b0001 << ALU_OUT_IN[1:0];
          wdataIn = {4{DATA_CACHE_STORE_DATA_IN[7:0]}};
        end
        2'b10: begin
          strbIn  = ALU_OUT_IN[1] ? 4'b1100 : 4'b0011;
          wdataIn = {2{DATA_CACHE_STORE_DATA_IN[15:0]}};
        end
        2'b11: begin
          strbIn  = 4'b1111;
          wdataIn = DATA_CACHE_STORE_DATA_IN;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    trapIn = 1'b0;
    if (isLoadIn) begin
      case (DATA_CACHE_LOAD_IN)
        3'd2, 3'd5: trapIn = ALU_OUT_IN[0];
        3'd3:       trapIn = |ALU_OUT_IN[1:0];
        default:    ;
      endcase
    end else begin
      case (DATA_CACHE_STORE_IN)
        2'b10:   trapIn = ALU_OUT_IN[0];
        2'b11:   trapIn = |ALU_OUT_IN[1:0];
        default: ;
      endcase
    end
  end
`else
  assign trapIn = 1'b0;
`endif

  // Half selection looks only at addr[1], which also realises the forced alignment.
  always_comb begin
    byteLane = MEM_RDATA[{addr_q[1:0], 3'b000} +: 8];
    halfLane = addr_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    case (loadOp_q)
      3'd1:    loadData = {{24{byteLane[7]}}, byteLane};
      3'd2:    loadData = {{16{halfLane[15]}}, halfLane};
      3'd3:    loadData = MEM_RDATA;
      3'd4:    loadData = {24'h0, byteLane};
      3'd5:    loadData = {16'h0, halfLane};
      default: loadData = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    rd_d       = rd_q;
    rdWe_d     = rdWe_q;
    wbSel_d    = wbSel_q;
    loadOp_d   = loadOp_q;
    isLoad_d   = isLoad_q;
    addr_d     = addr_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memStrb_d  = memStrb_q;
    memWdata_d = memWdata_q;
    result_d   = result_q;
    busErr_d   = busErr_q;
    wbRd_d     = wbRd_q;
    wbData_d   = wbData_q;
    wbWe_d     = wbWe_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    STALL_OUT  = 1'b0;

    case (state_q)
      IDLE: begin
        STALL_OUT = isMemOpIn;
        if (isMemOpIn) begin
          rd_d     = RD_ADDRESS_IN;
          rdWe_d   = RD_WRITE_ENABLE_IN;
          wbSel_d  = WRITE_BACK_MUX_SELECT_IN;
          loadOp_d = DATA_CACHE_LOAD_IN;
          isLoad_d = isLoadIn;
          addr_d   = ALU_OUT_IN;
          result_d = ALU_OUT_IN;
          wbWe_d   = 1'b0;
          if (trapIn) begin
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
            state_d = DONE;
          end else begin
            state_d    = REQ;
            waitCnt_d  = 8'd0;
            memWe_d    = !isLoadIn;
            memAddr_d  = {ALU_OUT_IN[31:2], 2'b00};
            memStrb_d  = strbIn;
            memWdata_d = wdataIn;
          end
        end else begin
          wbRd_d   = RD_ADDRESS_IN;
          wbData_d = ALU_OUT_IN;
          wbWe_d   = RD_WRITE_ENABLE_IN;
        end
      end
      REQ: begin
        STALL_OUT = 1'b1;
        waitCnt_d = waitCnt_q + 8'd1;
        if (MEM_REQ_READY) begin
          state_d = RESP;
        end else if (waitCnt_q >= WAIT_LIMIT) begin
          busErr_d = 1'b1;
          state_d  = DONE;
        end
      end
      RESP: begin
        STALL_OUT = 1'b1;
        waitCnt_d = waitCnt_q + 8'd1;
        if (MEM_RESP_VALID) begin
          result_d = (isLoad_q && wbSel_q) ? loadData : addr_q;
          state_d  = DONE;
        end else if (waitCnt_q >= WAIT_LIMIT) begin
          busErr_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        wbRd_d   = rd_q;
        wbData_d = result_q;
        wbWe_d   = rdWe_q && isLoad_q && !busErr_q;
`ifdef LSU_MISALIGN_TRAP_EN
        if (misalign_q) wbWe_d = 1'b0;
        misalign_d = 1'b0;
`endif
        busErr_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      waitCnt_q  <= 8'd0;
      rd_q       <= 5'd0;
      rdWe_q     <= 1'b0;
      wbSel_q    <= 1'b0;
      loadOp_q   <= 3'd0;
      isLoad_q   <= 1'b0;
      addr_q     <= 32'h0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 32'h0;
      memStrb_q  <= 4'h0;
      memWdata_q <= 32'h0;
      result_q   <= 32'h0;
      busErr_q   <= 1'b0;
      wbRd_q     <= 5'd0;
      wbData_q   <= 32'h0;
      wbWe_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      rd_q       <= rd_d;
      rdWe_q     <= rdWe_d;
      wbSel_q    <= wbSel_d;
      loadOp_q   <= loadOp_d;
      isLoad_q   <= isLoad_d;
      addr_q     <= addr_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memStrb_q  <= memStrb_d;
      memWdata_q <= memWdata_d;
      result_q   <= result_d;
      busErr_q   <= busErr_d;
      wbRd_q     <= wbRd_d;
      wbData_q   <= wbData_d;
      wbWe_q     <= wbWe_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign MEM_REQ_VALID       = (state_q == REQ);
  assign MEM_WE              = memWe_q;
  assign MEM_ADDR            = memAddr_q;
  assign MEM_WSTRB           = memStrb_q;
  assign MEM_WDATA           = memWdata_q;
  assign RD_ADDRESS_OUT      = wbRd_q;
  assign WB_DATA_OUT         = wbData_q;
  assign RD_WRITE_ENABLE_OUT = wbWe_q;
  assign BUS_ERROR_OUT       = busErr_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign MISALIGN_OUT        = misalign_q;
`else
  assign MISALIGN_OUT        = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RISC-V pipeline, directly downstream of the data-memory pipeline register. Consumes the registered address, load/store codes, store data and write-back controls, and runs one transaction at a time on a valid/ready data-memory bus. Aligns and sign/zero-extends load data and stalls upstream while an access is in flight. Presents a registered write-back bundle to the write-back stage.

## Interface
- `MAX_WAIT`, 255: cycles allowed in REQ+RESP before bus-error abort (8-bit counter; legal range 1–255).
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `RD_ADDRESS_IN` in 5: destination register.
- `ALU_OUT_IN` in 32: effective address, or ALU result for non-memory ops.
- `DATA_CACHE_LOAD_IN` in 3: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 treated as none.
- `DATA_CACHE_STORE_IN` in 2: 00 none, 01 SB, 10 SH, 11 SW.
- `DATA_CACHE_STORE_DATA_IN` in 32: store source (rs2).
- `WRITE_BACK_MUX_SELECT_IN` in 1: 1 = write back load data, 0 = ALU result.
- `RD_WRITE_ENABLE_IN` in 1: register-file write request.
- `STALL_OUT` out 1: combinational; holds the upstream stage.
- `MEM_REQ_VALID` out 1, `MEM_REQ_READY` in 1: request handshake.
- `MEM_WE` out 1, `MEM_ADDR` out 32 (bits [1:0] = 0), `MEM_WSTRB` out 4, `MEM_WDATA` out 32.
- `MEM_RESP_VALID` in 1, `MEM_RDATA` in 32: response for loads and store acks.
- `RD_ADDRESS_OUT` out 5, `WB_DATA_OUT` out 32, `RD_WRITE_ENABLE_OUT` out 1: registered write-back bundle.
- `BUS_ERROR_OUT` out 1, `MISALIGN_OUT` out 1: one-cycle fault pulses.

## Operation
- States: IDLE, REQ, RESP, DONE. Memory op = load code 001–101 or store code ≠ 00. A load code takes precedence if both are set.
- IDLE, no mem op: `STALL_OUT`=0. Write-back registers load {RD_ADDRESS_IN, ALU_OUT_IN, RD_WRITE_ENABLE_IN}.
- IDLE, mem op: `STALL_OUT`=1. Latch the op, word address, strobes and lane-replicated write data; go to REQ. The write-back bundle loads a bubble (`RD_WRITE_ENABLE_OUT`=0).
- REQ: `MEM_REQ_VALID`=1 with address, data and strobes held stable. On `MEM_REQ_READY` go to RESP.
- RESP: on `MEM_RESP_VALID`, capture the aligned load result and go to DONE.
- DONE: `STALL_OUT`=0 for exactly one cycle so upstream advances. Write-back registers load {latched rd, result, RD_WRITE_ENABLE_IN & is_load}. Go to IDLE. The op still at the input in DONE is never relaunched.
- Store lanes:
  - SB: byte replicated ×4, `MEM_WSTRB` = 1<<addr[1:0].
  - SH: half replicated ×2, strobes 0011 or 1100.
  - SW: strobes 1111.
- Loads select the byte/half at addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- WRITE_BACK_MUX_SELECT=0 on a load writes back the latched address instead of load data.
- Timeout: the wait counter is cleared on entering REQ and increments in REQ/RESP. On reaching MAX_WAIT: pulse `BUS_ERROR_OUT`, drop `MEM_REQ_VALID`, go to DONE with write enable suppressed.
- A `MEM_RESP_VALID` seen in IDLE, REQ or DONE is ignored.

## Timing
- Non-memory op: 1-cycle latency, no stall.
- Memory op with zero-wait bus: IDLE→REQ→RESP→DONE = 4 cycles. `STALL_OUT` is high for 3 cycles.
- `MEM_REQ_VALID` is a registered state decode and never deasserts before ready, except on timeout or reset.
- Reset (async, any state):
  - State → IDLE; counter → 0.
  - All outputs → 0: `MEM_REQ_VALID`, `MEM_WE`, `MEM_ADDR`, `MEM_WSTRB`, `MEM_WDATA`, `RD_*_OUT`, `WB_DATA_OUT`, the fault pulses. `STALL_OUT` is then driven by the IDLE rule.
  - An in-flight transaction is abandoned and its late response ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) issues no bus request. IDLE goes directly to DONE, `MISALIGN_OUT` pulses in DONE, and the write enable is suppressed.
- Undefined: low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0), the access proceeds normally, and `MISALIGN_OUT` is tied 0.

## Test plan
- ADD pass-through: ALU_OUT_IN=0x12345678, rd=5, we=1 → next cycle WB_DATA_OUT=0x12345678, RD_ADDRESS_OUT=5, RD_WRITE_ENABLE_OUT=1, STALL_OUT never high.
- LB at 0x1003, MEM_RDATA=0x80FF_FFFF, ready and resp immediate → WB_DATA_OUT=0xFFFFFF80 in the cycle after DONE, STALL_OUT high 3 cycles. LBU at the same address → 0x00000080.
- SH at 0x2002, data 0xAAAA_BEEF → MEM_ADDR=0x2000, MEM_WSTRB=1100, MEM_WDATA=0xBEEFBEEF, MEM_WE=1, RD_WRITE_ENABLE_OUT=0.
- MEM_REQ_READY held 0, MAX_WAIT=4 → BUS_ERROR_OUT pulses once, MEM_REQ_VALID drops, STALL_OUT releases, no register write.
- LW at 0x3001: with LSU_MISALIGN_TRAP_EN → MISALIGN_OUT pulse, MEM_REQ_VALID stays 0. Without → MEM_ADDR=0x3000, normal load.
- RST asserted while in RESP → MEM_REQ_VALID and the write-back outputs go 0 immediately. A MEM_RESP_VALID after reset is ignored and the next ALU op passes through normally.
